imem_fetch_responder: RTL and testbench

Instruction-memory responder serving the fetch side of the Y86-64 pipeline over a valid/ready request/response handshake. Holds a byte-addressed instruction store, accepts a PC and returns the 10-byte instruction window starting at that PC, assembled over multiple cycles. The window is big-endian by byte: the byte at PC sits in bits [0:7]. The block also provides a byte load port for programming the store and flags windows that run past the end of memory.

---
 rtl/imem_fetch_responder.sv | 123 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder for the Y86-64 fetch stage. Returns the 10-byte
// window at a requested PC, assembling it BYTES_PER_CYCLE bytes per cycle.
module imem_fetch_responder #(
    parameter int unsigned MEM_BYTES       = 1024,
    parameter int unsigned BYTES_PER_CYCLE = 2,
    localparam int unsigned AW             = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_pc,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [0:79]   rsp_instr,
    output logic [63:0]   rsp_pc,
    output logic          rsp_error,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_drop,
    output logic          busy
);

    localparam int unsigned WIN_BYTES = 10;
    localparam int unsigned CHUNK_W   = 8 * BYTES_PER_CYCLE;
    localparam logic [3:0]  STEP      = 4'(BYTES_PER_CYCLE);
    localparam logic [3:0]  LAST_CNT  = 4'(WIN_BYTES);
    localparam logic [64:0] LAST_PC   = 65'(MEM_BYTES - WIN_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_RESP
    } state_t;

    state_t             state_q;
    logic [63:0]        pc_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW-1:0]      rd_ptr_d;
    logic [3:0]         cnt_q;
    logic [3:0]         cnt_d;
    logic [0:79]        instr_q;
    logic [0:79]        instr_d;
    logic               err_q;
    logic               ld_drop_q;
    logic               mem_we;
    logic               pc_oob;
    logic [CHUNK_W-1:0] chunk;

    logic [7:0] mem_q [MEM_BYTES];

    // Loads are only honoured while idle, so a load on the accepting edge
    // is already in the array when READ starts copying.
    assign mem_we = ld_en && (state_q == S_IDLE);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // Lowest-address byte of each beat goes to the most significant end.
    for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_chunk
        assign chunk[8*(BYTES_PER_CYCLE-1-g) +: 8] = mem_q[rd_ptr_q + AW'(g)];
    end

    // Bytes arrive in address order, so shifting each beat in from the low
    // end leaves mem[PC] in bits [0:7] once the window is full.
    assign instr_d  = (instr_q << CHUNK_W) | 80'(chunk);
    assign cnt_d    = cnt_q + STEP;
    assign rd_ptr_d = rd_ptr_q + AW'(BYTES_PER_CYCLE);
    assign pc_oob   = {1'b0, req_pc} > LAST_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            instr_q   <= '0;
            err_q     <= 1'b0;
            ld_drop_q <= 1'b0;
        end else begin
            ld_drop_q <= ld_en && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        pc_q     <= req_pc;
                        rd_ptr_q <= req_pc[AW-1:0];
                        cnt_q    <= '0;
                        instr_q  <= '0;
                        err_q    <= pc_oob;
                        state_q  <= pc_oob ? S_RESP : S_READ;
                    end
                end
                S_READ: begin
                    instr_q  <= instr_d;
                    rd_ptr_q <= rd_ptr_d;
                    cnt_q    <= cnt_d;
                    if (cnt_d == LAST_CNT) begin
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q != S_IDLE);
    assign rsp_instr = instr_q;
    assign rsp_pc    = pc_q;
    assign rsp_error = err_q;
    assign ld_drop   = ld_drop_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: scoreboard of expected windows computed from a
// byte-array memory model, plus directed stall, load-drop, reset and width cases.
module tb_imem_fetch_responder;

    localparam int MEM = 1024;
    localparam int LIM = MEM - 10;

    typedef struct {
        logic [63:0] pc;
        logic [79:0] instr;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [0:79] rsp_instr;
    logic [63:0] rsp_pc;
    logic        rsp_error;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [7:0]  ld_data;
    logic        ld_drop;
    logic        busy;

    logic        v_req_valid;
    logic [63:0] v_req_pc;
    logic        b1_rr, b1_rv, b1_re, b1_ld, b1_bz;
    logic        b5_rr, b5_rv, b5_re, b5_ld, b5_bz;
    logic        b10_rr, b10_rv, b10_re, b10_ld, b10_bz;
    logic [0:79] b1_ri, b5_ri, b10_ri;
    logic [63:0] b1_rp, b5_rp, b10_rp;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rr_mode = 0;
    logic [7:0] ref_mem [MEM];
    exp_t exp_q[$];
    exp_t mon_e;
    logic rv_prev = 1'b0;
    int   rise_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_fetch_responder u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_error(rsp_error),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_drop(ld_drop), .busy(busy)
    );

    imem_fetch_responder #(.BYTES_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v_req_valid), .req_ready(b1_rr),
        .req_pc(v_req_pc), .rsp_valid(b1_rv), .rsp_ready(1'b1),
        .rsp_instr(b1_ri), .rsp_pc(b1_rp), .rsp_error(b1_re),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_drop(b1_ld), .busy(b1_bz)
    );

    imem_fetch_responder #(.BYTES_PER_CYCLE(5)) u_b5 (
        .clk(clk), .rst_n(rst_n), .req_valid(v_req_valid), .req_ready(b5_rr),
        .req_pc(v_req_pc), .rsp_valid(b5_rv), .rsp_ready(1'b1),
        .rsp_instr(b5_ri), .rsp_pc(b5_rp), .rsp_error(b5_re),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_drop(b5_ld), .busy(b5_bz)
    );

    imem_fetch_responder #(.BYTES_PER_CYCLE(10)) u_b10 (
        .clk(clk), .rst_n(rst_n), .req_valid(v_req_valid), .req_ready(b10_rr),
        .req_pc(v_req_pc), .rsp_valid(b10_rv), .rsp_ready(1'b1),
        .rsp_instr(b10_ri), .rsp_pc(b10_rp), .rsp_error(b10_re),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_drop(b10_ld), .busy(b10_bz)
    );

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic timeout(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", nm);
    endtask

    // Window expected at pc: ten consecutive bytes, first byte most significant.
    function automatic exp_t model(input logic [63:0] pc, input int acc);
        exp_t e;
        e.pc    = pc;
        e.acc   = acc;
        e.err   = (pc > 64'(LIM));
        e.lat   = e.err ? 1 : 6;
        e.instr = '0;
        if (!e.err) begin
            for (int k = 0; k < 10; k++) begin
                e.instr[79-8*k -: 8] = ref_mem[int'(pc[9:0]) + k];
            end
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        case (rr_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    initial forever begin
        @(negedge clk);
        if (rsp_valid === 1'b1 && rv_prev !== 1'b1) rise_cyc = cyc;
        rv_prev = rsp_valid;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_rsp");
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_instr", 80'(rsp_instr), mon_e.instr);
                chk("rsp_pc", 80'(rsp_pc), 80'(mon_e.pc));
                chk("rsp_error", 80'(rsp_error), 80'(mon_e.err));
                chk("rsp_latency", 80'(rise_cyc - mon_e.acc), 80'(mon_e.lat));
            end
        end
    end

    task automatic fetch(input logic [63:0] pc, input bit with_ld = 1'b0,
                         input logic [9:0] la = '0, input logic [7:0] ldv = '0);
        int n = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_pc    = pc;
        if (with_ld) begin
            ld_en = 1'b1; ld_addr = la; ld_data = ldv;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 100);
        if (!req_ready) begin
            timeout("req_accept");
        end else begin
            if (with_ld) ref_mem[la] = ldv;
            exp_q.push_back(model(pc, cyc));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        ld_en     = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req_ready && exp_q.size() == 0) && n < 300);
        if (!(req_ready && exp_q.size() == 0)) timeout("wait_idle");
    endtask

    task automatic load(input logic [9:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    initial begin
        logic [7:0]  tp [10];
        logic [63:0] pc;
        logic [79:0] vexp;
        bit          s1, s5, s10;
        int          acc, n, hits;

        tp = '{8'h10, 8'h10, 8'h20, 8'h12, 8'h30, 8'hF2, 8'h00, 8'h00, 8'h00, 8'h00};
        rst_n = 1'b0; req_valid = 1'b0; req_pc = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        v_req_valid = 1'b0; v_req_pc = '0;
        #12;
        chk("rst_req_ready", 80'(req_ready), 80'(1));
        chk("rst_rsp_valid", 80'(rsp_valid), 80'(0));
        chk("rst_rsp_instr", 80'(rsp_instr), 80'(0));
        chk("rst_rsp_pc", 80'(rsp_pc), 80'(0));
        chk("rst_rsp_error", 80'(rsp_error), 80'(0));
        chk("rst_ld_drop", 80'(ld_drop), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int a = 0; a < MEM; a++) begin
            @(posedge clk); #1;
            ld_en   = 1'b1;
            ld_addr = 10'(a);
            ld_data = (a < 10) ? tp[a] : (a >= LIM) ? 8'(a - LIM) : 8'($urandom);
            ref_mem[a] = ld_data;
        end
        @(posedge clk); #1;
        ld_en = 1'b0;

        fetch(64'd0);
        fetch(64'd1014);
        fetch(64'd1015);
        fetch(64'hFFFF_FFFF_FFFF_FFFF);
        fetch(64'h1_0000_0000);
        fetch(64'd1024);
        wait_idle();

        // Narrow and wide datapaths: same window, different latency.
        vexp = model(64'd0, 0).instr;
        @(posedge clk); #1;
        v_req_valid = 1'b1; v_req_pc = '0;
        @(negedge clk);
        chk("bpc1_idle", 80'({b1_rr, b1_bz, b1_ld}), 80'(3'b100));
        chk("bpc5_idle", 80'({b5_rr, b5_bz, b5_ld}), 80'(3'b100));
        chk("bpc10_idle", 80'({b10_rr, b10_bz, b10_ld}), 80'(3'b100));
        acc = cyc;
        @(posedge clk); #1;
        v_req_valid = 1'b0;
        s1 = 0; s5 = 0; s10 = 0;
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            if (b1_rv && !s1) begin
                s1 = 1;
                chk("bpc1_latency", 80'(cyc - acc), 80'(11));
                chk("bpc1_instr", 80'(b1_ri), vexp);
                chk("bpc1_pc_err", 80'({b1_re, b1_rp}), 80'(0));
            end
            if (b5_rv && !s5) begin
                s5 = 1;
                chk("bpc5_latency", 80'(cyc - acc), 80'(3));
                chk("bpc5_instr", 80'(b5_ri), vexp);
                chk("bpc5_pc_err", 80'({b5_re, b5_rp}), 80'(0));
            end
            if (b10_rv && !s10) begin
                s10 = 1;
                chk("bpc10_latency", 80'(cyc - acc), 80'(2));
                chk("bpc10_instr", 80'(b10_ri), vexp);
                chk("bpc10_pc_err", 80'({b10_re, b10_rp}), 80'(0));
            end
        end
        chk("bpc_all_responded", 80'({s1, s5, s10}), 80'(3'b111));

        // Consumer stall with a request waiting behind it.
        fetch(64'd100);
        rr_mode = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        if (!rsp_valid) timeout("stall_rsp_valid");
        @(posedge clk); #1;
        req_valid = 1'b1; req_pc = 64'd200;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 80'(rsp_valid), 80'(1));
            chk("stall_req_ready", 80'(req_ready), 80'(0));
            if (exp_q.size() > 0) begin
                chk("stall_instr", 80'(rsp_instr), exp_q[0].instr);
                chk("stall_pc_err", 80'({rsp_error, rsp_pc}), 80'({exp_q[0].err, exp_q[0].pc}));
            end
        end
        @(posedge clk); #1;
        rr_mode = 0;
        @(negedge clk);
        chk("handshake_req_ready", 80'(req_ready), 80'(0));
        @(negedge clk);
        chk("idle_after_handshake", 80'(req_ready), 80'(1));
        exp_q.push_back(model(64'd200, cyc));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();

        // Load during READ is dropped; load on the accepting edge lands.
        fetch(64'd0);
        ld_en = 1'b1; ld_addr = 10'd3; ld_data = 8'hAA;
        @(posedge clk); #1;
        ld_en = 1'b0;
        chk("ld_drop_pulse", 80'(ld_drop), 80'(1));
        @(posedge clk); #1;
        chk("ld_drop_clear", 80'(ld_drop), 80'(0));
        wait_idle();
        fetch(64'd0);
        wait_idle();
        fetch(64'd0, 1'b1, 10'd2, 8'h55);
        wait_idle();

        rr_mode = 2;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                load(10'($urandom_range(0, MEM - 1)), 8'($urandom));
            end
            case ($urandom_range(0, 9))
                0:       pc = 64'(LIM + 1 + $urandom_range(0, 20));
                1:       pc = {$urandom, $urandom};
                2:       pc = 64'(LIM);
                default: pc = 64'($urandom_range(0, LIM));
            endcase
            fetch(pc);
        end
        rr_mode = 0;
        wait_idle();

        // Reset in the middle of a read aborts it without a response.
        fetch(64'd20);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 80'(req_ready), 80'(1));
        chk("mid_rst_rsp_valid", 80'(rsp_valid), 80'(0));
        chk("mid_rst_rsp_instr", 80'(rsp_instr), 80'(0));
        chk("mid_rst_rsp_pc_err", 80'({rsp_error, rsp_pc}), 80'(0));
        chk("mid_rst_busy_drop", 80'({busy, ld_drop}), 80'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        hits = 0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        chk("no_rsp_after_reset", 80'(hits), 80'(0));
        fetch(64'd500);
        wait_idle();

        chk("queue_drained", 80'(exp_q.size()), 80'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
